set_assoc_cache: RTL

//  Parametrised N-way set-associative write-back, write-allocate data cache with multi-word lines.

---
 rtl/cache_pkg.sv | 36 +++
 rtl/set_assoc_cache_plru.sv | 58 +++++
 rtl/set_assoc_cache.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// +---------------------------------------------------------------------------+
// | cache_pkg                                                                 |
// | Shared miss-FSM state type and address-field width helpers for the cache. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2,
    ST_INSTALL   = 2'd3
  } cache_state_t;

  function automatic int bo_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int wo_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int iw_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tw_bits(input int addr_width, input int data_width,
                                 input int num_sets, input int words_per_line);
    return addr_width - iw_bits(num_sets) - wo_bits(words_per_line) - bo_bits(data_width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/set_assoc_cache_plru.sv
// +---------------------------------------------------------------------------+
// | plru_tree                                                                 |
// | Binary-tree pseudo-LRU: picks the victim way and computes the tree bits   |
// | after touching a way (path bits flipped to point away from it).           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module plru_tree #(
  parameter  int NUM_WAYS = 2,
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int TREE_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
  input  logic [TREE_W-1:0] tree_bits,
  input  logic [WAY_W-1:0]  access_way,
  output logic [WAY_W-1:0]  victim_way,
  output logic [TREE_W-1:0] next_bits
);

  localparam int c_levels = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 0;
  localparam int c_pad_w  = 1 << WAY_W;

  // Heap-numbered nodes (root = 1); node n's bit lives at position n-1.
  logic [c_pad_w-1:0] w_cur;
  logic [c_pad_w-1:0] w_nxt;
  logic [WAY_W:0]     w_vnode;
  logic [WAY_W:0]     w_anode;
  logic [WAY_W-1:0]   w_vidx;
  logic [WAY_W-1:0]   w_aidx;
  logic [WAY_W-1:0]   w_acc;
  logic               w_dir;

  always_comb begin
    w_cur              = '0;
    w_cur[TREE_W-1:0]  = tree_bits;
    w_nxt              = w_cur;
    w_vnode            = (WAY_W + 1)'(1);
    w_anode            = (WAY_W + 1)'(1);
    w_vidx             = '0;
    w_aidx             = '0;
    w_acc              = access_way;
    w_dir              = 1'b0;
    for (int l = 0; l < c_levels; l++) begin
      w_vidx  = w_vnode[WAY_W-1:0] - WAY_W'(1);
      w_vnode = {w_vnode[WAY_W-1:0], w_cur[w_vidx]};
      w_aidx  = w_anode[WAY_W-1:0] - WAY_W'(1);
      w_dir   = w_acc[WAY_W-1];
      w_acc   = w_acc << 1;
      w_nxt[w_aidx] = ~w_dir;
      w_anode = {w_anode[WAY_W-1:0], w_dir};
    end
    victim_way = (NUM_WAYS > 1) ? w_vnode[WAY_W-1:0] : '0;
    next_bits  = w_nxt[TREE_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/set_assoc_cache.sv
// +---------------------------------------------------------------------------+
// | set_assoc_cache                                                           |
// | N-way set-associative write-back/write-allocate data cache with its own  |
// | miss FSM (writeback, burst refill, install, replay) and tree PLRU.        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_WAYS       = 2,
  parameter int NUM_SETS       = 256,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  input  logic                  mem_ack
);

  localparam int c_bo     = bo_bits(DATA_WIDTH);
  localparam int c_wo     = wo_bits(WORDS_PER_LINE);
  localparam int c_iw     = iw_bits(NUM_SETS);
  localparam int c_tw     = tw_bits(ADDR_WIDTH, DATA_WIDTH, NUM_SETS, WORDS_PER_LINE);
  localparam int c_way_w  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int c_tree_w = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
  localparam int c_beat_w = (c_wo > 0) ? c_wo : 1;
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(WORDS_PER_LINE - 1);

  logic [c_tw-1:0]       r_tag   [NUM_WAYS][NUM_SETS];
  logic [DATA_WIDTH-1:0] r_data  [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
  logic [NUM_WAYS-1:0]   r_valid [NUM_SETS];
  logic [NUM_WAYS-1:0]   r_dirty [NUM_SETS];
  logic [c_tree_w-1:0]   r_plru  [NUM_SETS];

  cache_state_t          r_state;
  cache_state_t          w_state_nxt;
  logic [c_beat_w-1:0]   r_beat;
  logic [c_way_w-1:0]    r_victim;
  logic [c_tw-1:0]       r_victim_tag;

  // Shift-based field extraction keeps WORDS_PER_LINE = 1 free of zero-width slices.
  logic [ADDR_WIDTH-1:0] w_word_sh, w_index_sh, w_tag_sh;
  logic [c_beat_w-1:0]   w_word;
  logic [c_iw-1:0]       w_index;
  logic [c_tw-1:0]       w_tag;

  assign w_word_sh  = addr >> c_bo;
  assign w_index_sh = addr >> (c_bo + c_wo);
  assign w_tag_sh   = addr >> (c_bo + c_wo + c_iw);
  assign w_word     = w_word_sh[c_beat_w-1:0] & c_last_beat;
  assign w_index    = w_index_sh[c_iw-1:0];
  assign w_tag      = w_tag_sh[c_tw-1:0];

  logic [NUM_WAYS-1:0] w_way_hit;

  generate
    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
      assign w_way_hit[g] = r_valid[w_index][g] && (r_tag[g][w_index] == w_tag);
    end
  endgenerate

  logic [c_way_w-1:0]  w_hit_way, w_fill_way, w_plru_victim, w_plru_access;
  logic [c_tree_w-1:0] w_plru_next;
  logic                w_lookup, w_hit_acc, w_miss, w_beat_done, w_last_beat;

  always_comb begin
    w_hit_way  = '0;
    w_fill_way = w_plru_victim;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (w_way_hit[i]) w_hit_way = c_way_w'(i);
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!r_valid[w_index][i]) w_fill_way = c_way_w'(i);
    end
  end

  assign w_lookup      = (r_state == ST_IDLE) && en;
  assign w_hit_acc     = w_lookup && (|w_way_hit);
  assign w_miss        = w_lookup && !(|w_way_hit);
  assign w_beat_done   = mem_req && mem_ack;
  assign w_last_beat   = (r_beat == c_last_beat);
  assign w_plru_access = (r_state == ST_INSTALL) ? r_victim : w_hit_way;

  plru_tree #(
    .NUM_WAYS (NUM_WAYS)
  ) u_plru (
    .tree_bits  (r_plru[w_index]),
    .access_way (w_plru_access),
    .victim_way (w_plru_victim),
    .next_bits  (w_plru_next)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_miss) begin
          w_state_nxt = (r_valid[w_index][w_fill_way] && r_dirty[w_index][w_fill_way])
                      ? ST_WRITEBACK : ST_REFILL;
        end
      end
      ST_WRITEBACK: if (w_beat_done && w_last_beat) w_state_nxt = ST_REFILL;
      ST_REFILL:    if (w_beat_done && w_last_beat) w_state_nxt = ST_INSTALL;
      ST_INSTALL:   w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  logic [c_tw-1:0]       w_beat_tag;
  logic [ADDR_WIDTH-1:0] w_beat_addr;

  assign w_beat_tag  = (r_state == ST_WRITEBACK) ? r_victim_tag : w_tag;
  assign w_beat_addr = (ADDR_WIDTH'(w_beat_tag) << (c_iw + c_wo + c_bo))
                     | (ADDR_WIDTH'(w_index)    << (c_wo + c_bo))
                     | (ADDR_WIDTH'(r_beat)     << c_bo);

  assign stall    = (r_state != ST_IDLE) || w_miss;
  assign mem_req  = (r_state == ST_WRITEBACK) || (r_state == ST_REFILL);
  assign mem_we   = (r_state == ST_WRITEBACK);
  assign mem_addr = mem_req ? w_beat_addr : '0;
  assign mem_wd   = mem_we ? r_data[r_victim][w_index][r_beat] : '0;
  assign rd       = w_hit_acc ? r_data[w_hit_way][w_index][w_word] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_victim     <= '0;
      r_victim_tag <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_beat_done) r_beat <= w_last_beat ? '0 : r_beat + c_beat_w'(1);
      if (w_miss) begin
        r_victim     <= w_fill_way;
        r_victim_tag <= r_tag[w_fill_way][w_index];
      end
      if (w_hit_acc) begin
        if (NUM_WAYS > 1) r_plru[w_index] <= w_plru_next;
        if (we) r_dirty[w_index][w_hit_way] <= 1'b1;
      end
      if (r_state == ST_INSTALL) begin
        r_valid[w_index][r_victim] <= 1'b1;
        r_dirty[w_index][r_victim] <= 1'b0;
        if (NUM_WAYS > 1) r_plru[w_index] <= w_plru_next;
      end
    end
  end

  // Tag and data storage are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_hit_acc && we) r_data[w_hit_way][w_index][w_word] <= wd;
    if ((r_state == ST_REFILL) && mem_ack) r_data[r_victim][w_index][r_beat] <= mem_rd;
    if (r_state == ST_INSTALL) r_tag[r_victim][w_index] <= w_tag;
  end

endmodule

`default_nettype wire
